// File: rtl/mem_stage_pkg.sv
// Shared constants and helpers for the MEM pipeline stage.
package mem_stage_pkg;

  localparam int unsigned MS_ADDR_W = 32;
  localparam int unsigned MS_RF_W   = 5;

  // Access size codes shared by MemRead and MemWrite.
  localparam logic [1:0] MEM_NONE = 2'b00;
  localparam logic [1:0] MEM_BYTE = 2'b01;
  localparam logic [1:0] MEM_HALF = 2'b10;
  localparam logic [1:0] MEM_WORD = 2'b11;

  // Natural alignment check: half needs bit 0 clear, word needs bits 1:0 clear.
  function automatic logic mem_misaligned(input logic [1:0] size, input logic [1:0] addr_lo);
    logic mis;
    mis = 1'b0;
    case (size)
      MEM_HALF: mis = addr_lo[0];
      MEM_WORD: mis = |addr_lo;
      default:  mis = 1'b0;
    endcase
    return mis;
  endfunction

endpackage

// File: rtl/mem_store_align.sv
// Byte-lane steering for stores: byte enables, lane-replicated data, alignment flag.
module mem_store_align import mem_stage_pkg::*; #(
  parameter int unsigned DATA_W = MS_ADDR_W
) (
  input  logic [1:0]        size,
  input  logic [1:0]        addr_lo,
  input  logic [DATA_W-1:0] data,
  output logic [3:0]        wen,
  output logic [DATA_W-1:0] wdata,
  output logic              misaligned
);

  // Decode size/offset into lane enables; a misaligned access enables no lane.
  always_comb begin
    misaligned = mem_misaligned(size, addr_lo);
    wen        = 4'h0;
    wdata      = data;
    case (size)
      MEM_BYTE: begin
        wen   = 4'b0001 << addr_lo;
        wdata = {(DATA_W/8){data[7:0]}};
      end
      MEM_HALF: begin
        wen   = 4'b0011 << {addr_lo[1], 1'b0};
        wdata = {(DATA_W/16){data[15:0]}};
      end
      MEM_WORD: wen = 4'hF;
      default:  wen = 4'h0;
    endcase
    if (misaligned) wen = 4'h0;
  end

endmodule

// File: rtl/mem_stage.sv
// MEM stage: EX->MEM pipeline register, data_sram request, wb handshake,
// misalignment flags and a forwarding / load-use view for ID.
module mem_stage import mem_stage_pkg::*; #(
  parameter int unsigned ADDR_W = MS_ADDR_W,
  parameter int unsigned RF_W   = MS_RF_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              es_valid,
  output logic              ms_allowin,
  input  logic              es_MemtoReg,
  input  logic              es_RegWrite,
  input  logic [1:0]        es_MemWrite,
  input  logic [1:0]        es_MemRead,
  input  logic [ADDR_W-1:0] es_Aluout,
  input  logic [ADDR_W-1:0] es_busB,
  input  logic [RF_W-1:0]   es_rd,
  input  logic              flush,
  input  logic              ws_allowin,
  output logic              ms_to_ws_valid,
  output logic              MemtoReg,
  output logic              RegWrite,
  output logic [1:0]        MemWrite,
  output logic [1:0]        MemRead,
  output logic [ADDR_W-1:0] Aluout,
  output logic [ADDR_W-1:0] busB,
  output logic [RF_W-1:0]   rd,
  output logic              data_sram_en,
  output logic [3:0]        data_sram_wen,
  output logic [ADDR_W-1:0] data_sram_addr,
  output logic [ADDR_W-1:0] data_sram_wdata,
  output logic              ms_fwd_valid,
  output logic [RF_W-1:0]   ms_fwd_rd,
  output logic [ADDR_W-1:0] ms_fwd_data,
  output logic              ms_load_use,
  output logic              ms_adel,
  output logic              ms_ades
);

  logic              ms_valid_q;
  logic              memtoreg_q, regwrite_q;
  logic [1:0]        memwrite_q, memread_q;
  logic [ADDR_W-1:0] aluout_q, busb_q;
  logic [RF_W-1:0]   rd_q;

  logic       es_store, es_mis;
  logic [1:0] es_size;
  logic       is_store, is_load, mis;
  logic [1:0] ms_size;
  logic [3:0] al_wen;

  // Incoming misalignment is resolved at capture so RegWrite to wb stays a pure register.
  always_comb begin
    es_store = |es_MemWrite;
    es_size  = es_store ? es_MemWrite : es_MemRead;
    es_mis   = mem_misaligned(es_size, es_Aluout[1:0]);
  end

  assign ms_allowin = !ms_valid_q || ws_allowin;

  // Pipeline register: capture on allowin; flush only kills an instruction left in place.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ms_valid_q <= 1'b0;
      memtoreg_q <= 1'b0;
      regwrite_q <= 1'b0;
      memwrite_q <= MEM_NONE;
      memread_q  <= MEM_NONE;
      aluout_q   <= '0;
      busb_q     <= '0;
      rd_q       <= '0;
    end else if (ms_allowin) begin
      ms_valid_q <= es_valid;
      memtoreg_q <= es_MemtoReg;
      regwrite_q <= es_RegWrite && !es_mis;
      memwrite_q <= es_MemWrite;
      memread_q  <= es_MemRead;
      aluout_q   <= es_Aluout;
      busb_q     <= es_busB;
      rd_q       <= es_rd;
    end else if (flush) begin
      ms_valid_q <= 1'b0;
    end
  end

  // Write wins when both read and write codes are set.
  always_comb begin
    is_store = |memwrite_q;
    is_load  = !is_store && (|memread_q);
    ms_size  = is_store ? memwrite_q : memread_q;
  end

  mem_store_align #(
    .DATA_W (ADDR_W)
  ) u_align (
    .size       (ms_size),
    .addr_lo    (aluout_q[1:0]),
    .data       (busb_q),
    .wen        (al_wen),
    .wdata      (data_sram_wdata),
    .misaligned (mis)
  );

  // Request only on the cycle the instruction advances into wb.
  always_comb begin
    ms_to_ws_valid = ms_valid_q && !flush;
    data_sram_en   = ms_valid_q && ws_allowin && !flush && (is_store || is_load) && !mis;
    data_sram_wen  = (data_sram_en && is_store) ? al_wen : 4'h0;
    data_sram_addr = {aluout_q[ADDR_W-1:2], 2'b00};
    ms_adel        = ms_valid_q && is_load && mis;
    ms_ades        = ms_valid_q && is_store && mis;
    ms_fwd_valid   = ms_valid_q && regwrite_q && (|rd_q);
    ms_fwd_rd      = rd_q;
    ms_fwd_data    = aluout_q;
    ms_load_use    = ms_valid_q && is_load;
  end

  assign MemtoReg = memtoreg_q;
  assign RegWrite = regwrite_q;
  assign MemWrite = memwrite_q;
  assign MemRead  = memread_q;
  assign Aluout   = aluout_q;
  assign busB     = busb_q;
  assign rd       = rd_q;

endmodule
